peaks_sequencer: RTL and testbench
==================================

# peaks_sequencer

Controller for the spectral peak finder. Accepts completed FFT frames from the FFT stage via a level request/acknowledge handshake and generates a clean `valid_in` pulse for the peak finder, with a guaranteed low gap between frames. It then waits for the peak compare to settle, captures the per-bin peak results, and serializes them into an output FIFO that the fingerprint/host readout drains with a valid/ready handshake. It also suppresses the peak finder's pipeline warm-up frames after reset.

## Interface
- `PEAKS`, 6, number of frequency bins/peaks per frame
- `FREQ_WIDTH`, 9, bits per frequency index
- `AMPL_WIDTH`, 24, bits per signed peak amplitude
- `TIME_WIDTH`, 16, bits of the peak finder's frame counter
- `PULSE_CYCLES`, 2, cycles `peaks_valid` is held high (≥1)
- `SETTLE_CYCLES`, 4, low cycles after the pulse before capture (≥1)
- `FIFO_DEPTH`, 8, output FIFO entries (power of 2)

Ports:
- `CLOCK_50`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `frame_ready`  in  1  FFT frame is stable on the peak finder input bus; held until `frame_ack`
- `frame_ack`  out  1  one-cycle pulse; the frame is latched and the source may change the bus
- `peaks_valid`  out  1  drives the peak finder `valid_in`
- `peaks_amp`  in  PEAKS*AMPL_WIDTH  flattened peak finder amplitudes; entry k is at [k*AMPL_WIDTH +: AMPL_WIDTH]
- `peaks_freq`  in  PEAKS*FREQ_WIDTH  flattened peak finder frequencies
- `peaks_time`  in  TIME_WIDTH  peak finder frame counter
- `out_valid`  out  1  FIFO not empty
- `out_ready`  in  1  consumer pop
- `out_idx`  out  3  bin index 0..PEAKS-1
- `out_freq`  out  FREQ_WIDTH  peak frequency
- `out_amp`  out  AMPL_WIDTH  signed peak amplitude
- `out_time`  out  TIME_WIDTH  frame time stamp
- `busy`  out  1  high in any state except IDLE

## Operation
- States:
  - IDLE → PULSE when `frame_ready`=1.
  - PULSE lasts PULSE_CYCLES cycles with `peaks_valid`=1. `frame_ack`=1 on its last cycle.
  - SETTLE lasts SETTLE_CYCLES cycles with `peaks_valid`=0.
  - After SETTLE, go to CAPTURE if warm-up is done, otherwise to IDLE.
  - CAPTURE (1 cycle) copies `peaks_amp`, `peaks_freq` and `peaks_time` into shadow registers and zeroes the drain index.
  - DRAIN pushes shadow entry[idx] once per cycle, then increments idx. When the last entry is pushed, return to IDLE.
- Warm-up: the peak finder output lags its input by two frames. A 2-bit counter counts accepted frames after reset. CAPTURE/DRAIN are skipped for the first two frames, which still get a full PULSE and SETTLE.
- FIFO push in DRAIN is stalled while the FIFO is full and no pop occurs in the same cycle. idx holds during a stall.
- FIFO: simultaneous push and pop is allowed at any occupancy, including full. Pop on an empty FIFO is ignored. Outputs show the head entry (first-word fall-through).
- The handshake is lossless: a frame arriving during DRAIN waits, because `frame_ready` is held until acked.

## Timing
- Reset values: all outputs 0, FIFO empty, warm-up counter 0, state IDLE. Reset is asynchronous, so `peaks_valid` drops immediately even mid-PULSE. Shadow registers and in-flight frames are discarded.
- `frame_ready` sampled high at cycle t:
  - `peaks_valid` is high at cycles t+1 … t+PULSE_CYCLES.
  - `frame_ack` is high at cycle t+PULSE_CYCLES.
  - CAPTURE is at t+PULSE_CYCLES+SETTLE_CYCLES+1.
  - The first push occurs the next cycle.
- `out_valid` rises the cycle after the first push.
- Defaults, no stall: frame-to-frame minimum period is 1+2+4+1+6 = 14 cycles. `peaks_valid` is low for at least SETTLE_CYCLES+1 cycles between pulses.
- The source must drop `frame_ready` the cycle after `frame_ack`. Because SETTLE_CYCLES≥1, a held request is never double-accepted.

## Configuration
- `PEAKS_SEQ_SKIP_ZERO_EN` defined: in DRAIN, an entry whose amplitude is 0 (no peak in that bin) is not pushed. idx still advances and that cycle is never a stall.
- `PEAKS_SEQ_SKIP_ZERO_EN` undefined: all PEAKS entries are pushed every frame.

## Test plan
- Reset, then 3 frames where frame 3's finder outputs are amp k*100+5 and freq 10+k: no pushes for frames 1–2. Frame 3 yields 6 entries in idx order 0..5 with matching amp/freq and `out_time`=`peaks_time` at capture.
- `frame_ready` rises at cycle 10 (defaults): `peaks_valid` is high at cycles 11–12, `frame_ack` at 12 only, and `peaks_valid` is low 13–16.
- `out_ready`=0 with FIFO_DEPTH=8 and two post-warm-up frames: FIFO fills at 8 and DRAIN stalls at frame 2 idx 2. `frame_ready` is not acked. Raising `out_ready` delivers all 12 entries in order with none lost.
- Full FIFO with `out_ready`=1 during DRAIN: push and pop in the same cycle, occupancy stays at 8 and there is no stall cycle.
- Assert `reset_n`=0 mid-PULSE: `peaks_valid` is 0 within the same cycle (asynchronous) and `out_valid`=0. The next two frames are suppressed again.
- With `PEAKS_SEQ_SKIP_ZERO_EN` defined, amps {0,7,0,0,-3,9} → exactly 3 entries: idx 1, 4, 5.

Source files
------------

// File: rtl/peaks_sequencer_if.sv
//------------------------------------------------------------------------------
// peaks_sequencer_if
//
// Bundles the frame handshake, the peak finder result bus and the output
// readout stream of the peaks sequencer.
//
//   master : the sequencer side (drives frame_ack, peaks_valid, out_*, busy)
//   slave  : the environment side (FFT source, peak finder, readout consumer)
//
// Signals:
//   frame_ready  source -> seq   frame stable on the finder input bus
//   frame_ack    seq -> source   one-cycle pulse, frame latched
//   peaks_valid  seq -> finder   finder valid_in
//   peaks_amp    finder -> seq   PEAKS signed amplitudes, entry k at [k*AMPL_WIDTH +: AMPL_WIDTH]
//   peaks_freq   finder -> seq   PEAKS frequency indices
//   peaks_time   finder -> seq   finder frame counter
//   out_valid    seq -> consumer FIFO not empty
//   out_ready    consumer -> seq pop
//   out_idx/out_freq/out_amp/out_time  head entry of the FIFO
//   busy         seq -> any      sequencer not idle
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface peaks_sequencer_if #(
  parameter int PEAKS      = 6,
  parameter int FREQ_WIDTH = 9,
  parameter int AMPL_WIDTH = 24,
  parameter int TIME_WIDTH = 16
);
  logic                         frame_ready;
  logic                         frame_ack;
  logic                         peaks_valid;
  logic [PEAKS*AMPL_WIDTH-1:0]  peaks_amp;
  logic [PEAKS*FREQ_WIDTH-1:0]  peaks_freq;
  logic [TIME_WIDTH-1:0]        peaks_time;
  logic                         out_valid;
  logic                         out_ready;
  logic [2:0]                   out_idx;
  logic [FREQ_WIDTH-1:0]        out_freq;
  logic signed [AMPL_WIDTH-1:0] out_amp;
  logic [TIME_WIDTH-1:0]        out_time;
  logic                         busy;

  modport master (
    input  frame_ready, peaks_amp, peaks_freq, peaks_time, out_ready,
    output frame_ack, peaks_valid, out_valid, out_idx, out_freq, out_amp,
           out_time, busy
  );

  modport slave (
    output frame_ready, peaks_amp, peaks_freq, peaks_time, out_ready,
    input  frame_ack, peaks_valid, out_valid, out_idx, out_freq, out_amp,
           out_time, busy
  );
endinterface

// File: rtl/peaks_sequencer.sv
//------------------------------------------------------------------------------
// peaks_sequencer
//
// Controller for the spectral peak finder. Accepts FFT frames over a level
// request/ack handshake, emits a clean peaks_valid pulse followed by a settle
// gap, captures the per-bin peak results into shadow registers and serializes
// them into a first-word fall-through output FIFO. The first two frames after
// reset only pulse the finder (its output lags its input by two frames).
//
// Ports:
//   CLOCK_50  sole clock
//   reset_n   asynchronous active-low reset
//   bus       peaks_sequencer_if.master (handshake, finder results, readout)
//
// Build option:
//   PEAKS_SEQ_SKIP_ZERO_EN  when defined, bins whose amplitude is zero are not
//                           pushed into the FIFO (the drain index still walks
//                           every bin, one per cycle, without stalling).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module peaks_sequencer #(
  parameter int PEAKS         = 6,
  parameter int FREQ_WIDTH    = 9,
  parameter int AMPL_WIDTH    = 24,
  parameter int TIME_WIDTH    = 16,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  peaks_sequencer_if.master bus
);

  localparam int TMR_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef logic [TMR_W-1:0] tmr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam tmr_t       PULSE_LAST  = tmr_t'(PULSE_CYCLES - 1);
  localparam tmr_t       SETTLE_LAST = tmr_t'(SETTLE_CYCLES - 1);
  localparam cnt_t       FULL_CNT    = cnt_t'(FIFO_DEPTH);
  localparam logic [2:0] IDX_LAST    = 3'(PEAKS - 1);
  localparam logic [1:0] WARM_FRAMES = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_SETTLE, S_CAPTURE, S_DRAIN
  } state_t;

  typedef struct packed {
    logic [2:0]                   idx;
    logic [FREQ_WIDTH-1:0]        freq;
    logic signed [AMPL_WIDTH-1:0] amp;
    logic [TIME_WIDTH-1:0]        tstamp;
  } entry_t;

  state_t               state_q, state_d;
  tmr_t                 tmr_q, tmr_d;
  logic [1:0]           warm_q, warm_d;
  logic [2:0]           idx_q, idx_d;
  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
  cnt_t                 cnt_q, cnt_d;

  logic signed [AMPL_WIDTH-1:0] shd_amp_q  [PEAKS];
  logic [FREQ_WIDTH-1:0]        shd_freq_q [PEAKS];
  logic [TIME_WIDTH-1:0]        shd_time_q;
  entry_t                       mem_q [FIFO_DEPTH];

  logic   pulse_o, ack_o, busy_o, push_req;
  logic   entry_live;
  logic   fifo_empty, fifo_full, pop, push_ok;
  entry_t push_entry, head;

`ifdef PEAKS_SEQ_SKIP_ZERO_EN
  assign entry_live = (shd_amp_q[idx_q] != '0);
`else
  assign entry_live = 1'b1;
`endif

  // ---- FSM state register ----
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---- FSM next state and sequencing counters ----
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    warm_d  = warm_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.frame_ready) begin
          state_d = S_PULSE;
          tmr_d   = '0;
        end
      end
      S_PULSE: begin
        if (tmr_q == PULSE_LAST) begin
          state_d = S_SETTLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d = '0;
          // Warm-up frames stop here; the counter saturates at WARM_FRAMES.
          if (warm_q == WARM_FRAMES) begin
            state_d = S_CAPTURE;
          end else begin
            state_d = S_IDLE;
            warm_d  = warm_q + 2'd1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_DRAIN;
        idx_d   = '0;
      end
      S_DRAIN: begin
        // A skipped bin never waits on the FIFO; a live bin waits for room.
        if (!push_req || push_ok) begin
          if (idx_q == IDX_LAST) state_d = S_IDLE;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    pulse_o  = 1'b0;
    ack_o    = 1'b0;
    busy_o   = 1'b1;
    push_req = 1'b0;
    case (state_q)
      S_IDLE:  busy_o = 1'b0;
      S_PULSE: begin
        pulse_o = 1'b1;
        ack_o   = (tmr_q == PULSE_LAST);
      end
      S_DRAIN: push_req = entry_live;
      default: ;
    endcase
  end

  // ---- FIFO control: push may coincide with pop even when full ----
  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    pop        = bus.out_ready && !fifo_empty;
    push_ok    = push_req && (!fifo_full || pop);
    wr_d       = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    cnt_d      = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q  <= '0;
      warm_q <= '0;
      idx_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      tmr_q  <= tmr_d;
      warm_q <= warm_d;
      idx_q  <= idx_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  // ---- Shadow capture and FIFO storage (data only, no reset) ----
  assign push_entry = '{idx: idx_q, freq: shd_freq_q[idx_q],
                        amp: shd_amp_q[idx_q], tstamp: shd_time_q};

  always_ff @(posedge CLOCK_50) begin
    if (state_q == S_CAPTURE) begin
      for (int k = 0; k < PEAKS; k++) begin
        shd_amp_q[k]  <= bus.peaks_amp[k*AMPL_WIDTH +: AMPL_WIDTH];
        shd_freq_q[k] <= bus.peaks_freq[k*FREQ_WIDTH +: FREQ_WIDTH];
      end
      shd_time_q <= bus.peaks_time;
    end
    if (push_ok) mem_q[wr_q] <= push_entry;
  end

  // Readout fields are forced to zero while empty so they are defined after reset.
  assign head = mem_q[rd_q];

  assign bus.out_valid   = !fifo_empty;
  assign bus.out_idx     = fifo_empty ? '0 : head.idx;
  assign bus.out_freq    = fifo_empty ? '0 : head.freq;
  assign bus.out_amp     = fifo_empty ? '0 : head.amp;
  assign bus.out_time    = fifo_empty ? '0 : head.tstamp;
  assign bus.peaks_valid = pulse_o;
  assign bus.frame_ack   = ack_o;
  assign bus.busy        = busy_o;

endmodule

// File: tb/tb_peaks_sequencer.sv
`timescale 1ns/1ps
module tb_peaks_sequencer;
  localparam int PEAKS = 6;
  localparam int FW    = 9;
  localparam int AW    = 24;
  localparam int TW    = 16;
  localparam int PC    = 2;
  localparam int SC    = 4;
  localparam int FD    = 8;
  localparam int EW    = 3 + FW + AW + TW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  peaks_sequencer_if #(.PEAKS(PEAKS), .FREQ_WIDTH(FW), .AMPL_WIDTH(AW),
                       .TIME_WIDTH(TW)) bus ();

  peaks_sequencer #(.PEAKS(PEAKS), .FREQ_WIDTH(FW), .AMPL_WIDTH(AW),
                    .TIME_WIDTH(TW), .PULSE_CYCLES(PC), .SETTLE_CYCLES(SC),
                    .FIFO_DEPTH(FD)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus.master)
  );

  int n_pass = 0;
  int n_total = 0;
  int ready_mode = 1;
  int frames_since_reset = 0;

  logic [EW-1:0]          exp_q[$];
  logic [EW-1:0]          mon_e;
  logic signed [AW-1:0]   amp_arr  [PEAKS];
  logic [FW-1:0]          freq_arr [PEAKS];
  logic [TW-1:0]          time_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic apply_bus();
    for (int k = 0; k < PEAKS; k++) begin
      bus.peaks_amp[k*AW +: AW]  = amp_arr[k];
      bus.peaks_freq[k*FW +: FW] = freq_arr[k];
    end
    bus.peaks_time = time_v;
  endtask

  task automatic rand_bus(input bit nonzero);
    for (int k = 0; k < PEAKS; k++) begin
      amp_arr[k]  = AW'($urandom);
      if (nonzero && amp_arr[k] == '0) amp_arr[k] = 1;
      if (!nonzero && $urandom_range(0, 2) == 0) amp_arr[k] = '0;
      freq_arr[k] = FW'($urandom);
    end
    time_v = TW'($urandom);
    apply_bus();
  endtask

  // Reference rule: the third and later accepted frames since reset deliver
  // their bins in index order, carrying the frame's time stamp.
  task automatic model_on_ack();
    frames_since_reset++;
    if (frames_since_reset >= 3) begin
      for (int k = 0; k < PEAKS; k++) begin
`ifdef PEAKS_SEQ_SKIP_ZERO_EN
        if (amp_arr[k] == '0) continue;
`endif
        exp_q.push_back({3'(k), freq_arr[k], amp_arr[k], time_v});
      end
    end
  endtask

  // Drop the request the cycle after ack and keep the result bus stable
  // until the capture edge has passed.
  task automatic finish_frame();
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
    repeat (SC + 2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    int  n;
    bit  got;
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 2000) begin
      @(negedge clk);
      if (bus.frame_ack) got = 1'b1;
      else n++;
    end
    if (!got) begin
      check("ack_timeout", 64'(bus.frame_ack), 64'd1);
      bus.frame_ready = 1'b0;
      return;
    end
    model_on_ack();
    finish_frame();
  endtask

  // Only valid when the sequencer is idle at the call.
  task automatic send_timed();
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    for (int i = 0; i <= PC; i++) begin
      @(negedge clk);
      check("pulse_valid", 64'(bus.peaks_valid), 64'(i >= 1));
      check("pulse_ack", 64'(bus.frame_ack), 64'(i == PC));
      if (i < PC) begin
        @(posedge clk); #1;
      end
    end
    model_on_ack();
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
    for (int j = 1; j <= SC; j++) begin
      @(negedge clk);
      check("gap_valid", 64'(bus.peaks_valid), 64'd0);
      check("gap_busy", 64'(bus.busy), 64'd1);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int m);
    @(negedge clk);
    ready_mode = m;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy || bus.out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drained_queue", 64'(exp_q.size()), 64'd0);
    check("drained_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  // Sole driver of out_ready: 0 low, 1 high, otherwise random per cycle.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(bus.out_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_entry", 64'({bus.out_idx, bus.out_freq, bus.out_amp, bus.out_time}),
              64'(mon_e));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  seen;
    reset_n = 1'b0;
    bus.frame_ready = 1'b0;
    for (int k = 0; k < PEAKS; k++) begin
      amp_arr[k]  = '0;
      freq_arr[k] = '0;
    end
    time_v = '0;
    apply_bus();

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_peaks_valid", 64'(bus.peaks_valid), 64'd0);
    check("rst_frame_ack", 64'(bus.frame_ack), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_out_idx", 64'(bus.out_idx), 64'd0);
    check("rst_out_freq", 64'(bus.out_freq), 64'd0);
    check("rst_out_amp", 64'(bus.out_amp), 64'd0);
    check("rst_out_time", 64'(bus.out_time), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Warm-up frames, then the known-pattern frame
    rand_bus(1'b0);
    send_timed();
    rand_bus(1'b0);
    send_frame();
    for (int k = 0; k < PEAKS; k++) begin
      amp_arr[k]  = AW'(k * 100 + 5);
      freq_arr[k] = FW'(10 + k);
    end
    time_v = 16'h1234;
    apply_bus();
    send_timed();
    wait_drained();

    // Sparse amplitudes, including negative
    amp_arr[0] = 0;  amp_arr[1] = 7;  amp_arr[2] = 0;
    amp_arr[3] = 0;  amp_arr[4] = -3; amp_arr[5] = 9;
    for (int k = 0; k < PEAKS; k++) freq_arr[k] = FW'($urandom);
    time_v = TW'($urandom);
    apply_bus();
    send_frame();
    wait_drained();

    // Random frames with random back-pressure
    set_ready(2);
    for (int f = 0; f < 6; f++) begin
      rand_bus(1'b0);
      send_frame();
    end
    set_ready(1);
    wait_drained();

    // Fill the FIFO and stall the drain, then release with a pending request
    set_ready(0);
    repeat (2) @(posedge clk);
    #1;
    rand_bus(1'b1);
    send_frame();
    rand_bus(1'b1);
    send_frame();
    repeat (6) @(posedge clk);
    #1;
    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
    check("stall_busy", 64'(bus.busy), 64'd1);
    rand_bus(1'b1);
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.frame_ack) seen = 1;
    end
    check("no_ack_while_full", 64'(seen), 64'd0);
    set_ready(1);
    @(posedge clk); #2;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      check("ack_after_release", 64'(bus.frame_ack), 64'(i == 6));
      if (i < 6) @(posedge clk);
    end
    model_on_ack();
    finish_frame();
    wait_drained();

    // Asynchronous reset in the middle of a pulse
    set_ready(0);
    rand_bus(1'b1);
    send_frame();
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
    rand_bus(1'b1);
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_pulse", 64'(bus.peaks_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_peaks_valid", 64'(bus.peaks_valid), 64'd0);
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    exp_q.delete();
    frames_since_reset = 0;
    bus.frame_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    set_ready(1);
    repeat (2) @(posedge clk);
    #1;
    rand_bus(1'b1);
    send_timed();
    rand_bus(1'b1);
    send_frame();
    rand_bus(1'b0);
    send_frame();
    wait_drained();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
